// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control FSM.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   function automatic logic is_legal_opcode(input logic [6:0] op);
      return (op == OP_RTYPE) || (op == OP_IALU) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch condition evaluation: BEQ/BNE only; every other funct3 is illegal.
module branch_cond (
   input  logic [2:0] funct3,
   input  logic       zero,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
      illegal = (funct3 != 3'b000) && (funct3 != 3'b001);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I lab datapath.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 0,
   parameter bit          TRAP_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       trap,
   output logic [2:0] state_out
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retired_cnt
`endif
);

   state_t     state, state_nx;
   logic [6:0] op_q;
   logic [2:0] f3_q;
   logic [7:0] stall_cnt;
   logic       br_taken, br_illegal;
   logic       stalled, timeout, retire;

   branch_cond u_branch_cond (
      .funct3  (f3_q),
      .zero    (zero),
      .taken   (br_taken),
      .illegal (br_illegal)
   );

   assign stalled   = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
   assign timeout   = (MEM_TIMEOUT != 0) && stalled && (stall_cnt == 8'(MEM_TIMEOUT - 1));
   assign state_out = state;

   always_comb begin
      state_nx = state;
      retire   = 1'b0;
      case (state)
         ST_FETCH:  if (mem_ready) state_nx = ST_DECODE;
                    else if (timeout) state_nx = ST_TRAP;
         ST_DECODE: state_nx = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            case (op_q)
               OP_RTYPE, OP_IALU: state_nx = ST_WB;
               OP_LOAD, OP_STORE: state_nx = ST_MEM;
               OP_BRANCH: begin
                  state_nx = br_illegal ? ST_TRAP : ST_FETCH;
                  retire   = !br_illegal;
               end
               default:           state_nx = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_nx = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
               retire   = (op_q != OP_LOAD);
            end else if (timeout) begin
               state_nx = ST_TRAP;
            end
         end
         ST_WB: begin
            state_nx = ST_FETCH;
            retire   = 1'b1;
         end
         ST_TRAP:   if (!TRAP_STICKY) state_nx = ST_FETCH;
         default:   state_nx = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         op_q      <= '0;
         f3_q      <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_DECODE) begin
            op_q <= opcode;
            f3_q <= funct3;
         end
         // Counter only survives while we keep waiting in the same state.
         if (stalled && (state_nx == state)) stall_cnt <= stall_cnt + 8'd1;
         else                                stall_cnt <= '0;
      end
   end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)       retired_cnt <= '0;
      else if (retire) retired_cnt <= retired_cnt + 32'd1;
   end
`endif

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      trap       = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         ST_DECODE: alu_src_b = SRCB_IMM;
         ST_EXEC: begin
            case (op_q)
               OP_RTYPE:  begin alu_src_a = 1'b1; alu_src_b = SRCB_RS2; alu_op = ALUOP_FUNCT; end
               OP_IALU:   begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALUOP_FUNCT; end
               OP_LOAD, OP_STORE: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALUOP_ADD; end
               OP_BRANCH: begin
                  alu_src_a = 1'b1;
                  alu_src_b = SRCB_RS2;
                  alu_op    = ALUOP_SUB;
                  pc_write  = br_taken && !br_illegal;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            iord      = 1'b1;
            mem_read  = (op_q == OP_LOAD);
            mem_write = (op_q == OP_STORE);
         end
         ST_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (op_q == OP_LOAD);
         end
         ST_TRAP: trap = 1'b1;
         default: ;
      endcase
      // Reset aborts mid-instruction: no strobe may leak out in the reset cycle.
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         trap      = 1'b0;
      end
   end

endmodule
